key_debounce_events: RTL and testbench
======================================

KEY_DEBOUNCE_EVENTS -- requirements
Module: key_debounce_events

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable synchronized samples required to accept a key change (legal range 2..2^20).
REQ-002 SHALL have one clock and asynchronous active-low reset: CLOCK_50 in 1 system clock; RESET_N in 1 asynchronous active-low reset.
REQ-003 KEY  in  4  raw push-buttons, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-004 key_level  out  4  debounced state, active-high (1 = pressed).
REQ-005 key_press  out  4  one-cycle pulse per key on debounced press.
REQ-006 key_release  out  4  one-cycle pulse per key on debounced release.
REQ-007 evt_valid  out  1  press event available.
REQ-008 evt_key  out  2  key index (0..3) of the presented event.
REQ-009 evt_ready  in  1  consumer accepts event.
REQ-010 overflow  out  1  sticky lost-event flag.
REQ-011 overflow_clr  in  1  synchronous clear of overflow.

Function
REQ-012 Each KEY bit SHALL pass through a 2-flop synchronizer; the synchronized value s[i] is inverted so 1 = pressed.
REQ-013 Each key SHALL have an independent counter of width ceil(log2(DEBOUNCE_CYCLES)): s[i]==key_level[i] -> counter 0; else counter==DEBOUNCE_CYCLES-1 -> key_level[i] <= s[i], counter 0; else counter+1.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL reset the counter and leave key_level unchanged.
REQ-015 A clean KEY transition SHALL appear on key_level exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples the new KEY value.
REQ-016 key_press[i] / key_release[i] SHALL be high for exactly the first cycle in which key_level[i] reads 1 / 0 after a change; never both high for one key.
REQ-017 A 4-bit pending mask SHALL set bit i on the edge after key_press[i] is high.
REQ-018 Output stage SHALL hold one event: when evt_valid=0 or (evt_valid & evt_ready), it loads the lowest-index set pending bit into evt_key, sets evt_valid and clears that pending bit; if mask empty, evt_valid <= 0.
REQ-019 Transfer occurs on an edge with evt_valid=1 and evt_ready=1; evt_key and evt_valid SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-020 Latency key_press pulse -> evt_valid SHALL be 2 cycles when output stage and mask are empty; back-to-back transfers at one per cycle with evt_ready held high.
REQ-021 Simultaneous presses SHALL be delivered in ascending index order, one per transfer.
REQ-022 key_press[i] while pending[i] already set SHALL set overflow and not duplicate the event; an event for key i held in the output stage does not count as pending.
REQ-023 overflow SHALL clear on overflow_clr=1; a same-cycle overflow set SHALL win over clear.
REQ-024 evt_ready while evt_valid=0 SHALL have no effect.

Reset
REQ-025 RESET_N=0 SHALL immediately force: synchronizer flops 1 (released), counters 0, key_level 0, key_press 0, key_release 0, pending 0, evt_valid 0, evt_key 0, overflow 0.
REQ-026 A key held through reset release SHALL be treated as a new press: key_level rises 2+DEBOUNCE_CYCLES edges after release, with key_press pulse and event.
REQ-027 Reset asserted mid-debounce or with evt_valid=1 SHALL discard all in-flight state and events.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 KEY[0] 1->0 held -> key_level[0]=1 on edge 6, key_press[0] high one cycle, evt_valid=1 evt_key=0 two cycles later, cleared after evt_ready transfer.
REQ-029 KEY[2] low for 3 cycles then high, repeated -> key_level, pulses, evt_valid remain 0.
REQ-030 KEY[3] and KEY[1] pressed same cycle, evt_ready=1 -> events evt_key=1 then 3 on consecutive cycles.
REQ-031 evt_ready=0; press/release/press KEY[2] twice while first event in output stage, third press with pending[2] set -> overflow=1; overflow_clr -> 0.
REQ-032 KEY[0] held, RESET_N pulsed low mid-debounce -> all outputs 0 during reset; key_level[0]=1 six edges after release.
REQ-033 KEY[1] released after acceptance -> key_release[1] one cycle, no event, overflow unchanged.

Source files
------------

// File: rtl/key_debounce_events_if.sv
// Press-event handshake bundle.
//   evt_valid : producer -> consumer, an event is presented
//   evt_key   : producer -> consumer, key index (0..3) of the presented event
//   evt_ready : consumer -> producer, event accepted on this edge when evt_valid=1
interface key_debounce_events_if;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic       evt_ready;

  modport master (
    output evt_valid,
    output evt_key,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_key,
    output evt_ready
  );
endinterface

// File: rtl/key_debounce_events.sv
// Four-key push-button front end: synchronizes and debounces the raw active-low
// KEY inputs, produces debounced levels plus press/release pulses, and queues
// press events into a single-entry valid/ready output stage.
//   CLOCK_50     : system clock
//   RESET_N      : asynchronous active-low reset
//   KEY[3:0]     : raw buttons, active-low, asynchronous
//   key_level    : debounced state, 1 = pressed
//   key_press    : one-cycle pulse on debounced press
//   key_release  : one-cycle pulse on debounced release
//   overflow     : sticky flag, a press arrived while the same key was already pending
//   overflow_clr : synchronous clear of overflow (a same-cycle set wins)
//   evt          : press-event handshake (evt_valid / evt_key / evt_ready)
module key_debounce_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET_N,
  input  logic [3:0]                   KEY,
  output logic [3:0]                   key_level,
  output logic [3:0]                   key_press,
  output logic [3:0]                   key_release,
  output logic                         overflow,
  input  logic                         overflow_clr,
  key_debounce_events_if.master        evt
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0]            sync1;
  logic [NKEYS-1:0]            sync2;
  logic [NKEYS-1:0]            pressed_c;
  logic [NKEYS-1:0][CNT_W-1:0] cnt;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_d;
  logic [NKEYS-1:0]            level_d;
  logic [NKEYS-1:0]            press_d;
  logic [NKEYS-1:0]            release_d;
  logic [NKEYS-1:0]            pending;
  logic [NKEYS-1:0]            pending_d;
  logic [NKEYS-1:0]            take;
  logic                        evt_valid_q;
  logic                        evt_valid_d;
  logic [1:0]                  evt_key_q;
  logic [1:0]                  evt_key_d;
  logic                        load_en;
  logic                        ovf_set;
  logic                        overflow_d;

  // Two-flop synchronizer; idles at 1 (released) out of reset
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= KEY;
      sync2 <= sync1;
    end
  end

  assign pressed_c = ~sync2;

  // Per-key stability counter; the level flips only after DEBOUNCE_CYCLES
  // consecutive samples disagreeing with it, and any agreeing sample restarts.
  always_comb begin
    cnt_d     = cnt;
    level_d   = key_level;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (pressed_c[i] == key_level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt_d[i]     = '0;
        level_d[i]   = pressed_c[i];
        press_d[i]   = pressed_c[i];
        release_d[i] = ~pressed_c[i];
      end else begin
        cnt_d[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Output stage refills when empty or when its event is being transferred;
  // the lowest-index pending key wins.
  always_comb begin
    load_en     = !evt_valid_q || evt.evt_ready;
    take        = '0;
    evt_valid_d = evt_valid_q;
    evt_key_d   = evt_key_q;
    if (load_en) begin
      evt_valid_d = 1'b0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
        if (pending[i]) begin
          take        = '0;
          take[i]     = 1'b1;
          evt_key_d   = 2'(i);
          evt_valid_d = 1'b1;
        end
      end
    end
    // A press is lost only if its key stays pending across this edge
    ovf_set    = |(key_press & pending & ~take);
    pending_d  = (pending & ~take) | key_press;
    overflow_d = overflow;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt         <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      pending     <= '0;
      evt_valid_q <= 1'b0;
      evt_key_q   <= '0;
      overflow    <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      key_level   <= level_d;
      key_press   <= press_d;
      key_release <= release_d;
      pending     <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_key_q   <= evt_key_d;
      overflow    <= overflow_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_key   = evt_key_q;

endmodule

// File: tb/tb_key_debounce_events.sv
module tb_key_debounce_events;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       overflow;
  logic       overflow_clr;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce_events_if evt_if ();

  key_debounce_events #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .KEY          (key),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .evt          (evt_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    key              = 4'hF;
    overflow_clr     = 1'b0;
    evt_if.evt_ready = 1'b0;
    step(2);
    check("rst_level", 32'(key_level), 32'h0);
    check("rst_pulses", 32'({key_press, key_release}), 32'h0);
    check("rst_evt", 32'({evt_if.evt_valid, evt_if.evt_key, overflow}), 32'h0);
    rst_n = 1'b1;
    step(3);

    // Single clean press of KEY[0]
    key = 4'b1110;
    step(5);
    check("t028_level_early", 32'(key_level), 32'h0);
    step(1);
    check("t028_level", 32'(key_level), 32'h1);
    check("t028_press", 32'(key_press), 32'h1);
    check("t028_valid_early", 32'(evt_if.evt_valid), 32'h0);
    step(1);
    check("t028_press_gone", 32'(key_press), 32'h0);
    check("t028_valid_lat1", 32'(evt_if.evt_valid), 32'h0);
    step(1);
    check("t028_valid", 32'(evt_if.evt_valid), 32'h1);
    check("t028_key", 32'(evt_if.evt_key), 32'h0);
    evt_if.evt_ready = 1'b1;
    step(1);
    check("t028_drained", 32'(evt_if.evt_valid), 32'h0);
    evt_if.evt_ready = 1'b0;
    key = 4'hF;
    step(6);
    check("t028_release", 32'(key_release), 32'h1);
    check("t028_level_rel", 32'(key_level), 32'h0);
    step(3);
    check("t028_rel_no_evt", 32'(evt_if.evt_valid), 32'h0);

    // Glitches on KEY[2] shorter than the debounce window
    for (int r = 0; r < 2; r++) begin
      key = 4'b1011;
      for (int c = 0; c < 3; c++) begin
        step(1);
        check("t029_low", 32'({key_level, key_press, key_release, evt_if.evt_valid}), 32'h0);
      end
      key = 4'hF;
      for (int c = 0; c < 5; c++) begin
        step(1);
        check("t029_high", 32'({key_level, key_press, key_release, evt_if.evt_valid}), 32'h0);
      end
    end

    // Simultaneous KEY[3] and KEY[1] presses, ready held high
    evt_if.evt_ready = 1'b1;
    key = 4'b0101;
    step(6);
    check("t030_level", 32'(key_level), 32'hA);
    check("t030_press", 32'(key_press), 32'hA);
    step(1);
    check("t030_valid_lat1", 32'(evt_if.evt_valid), 32'h0);
    step(1);
    check("t030_first", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h5);
    step(1);
    check("t030_second", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h7);
    step(1);
    check("t030_empty", 32'(evt_if.evt_valid), 32'h0);

    // Release of KEY[1] only
    key = 4'b0111;
    step(6);
    check("t033_release", 32'(key_release), 32'h2);
    check("t033_level", 32'(key_level), 32'h8);
    check("t033_press", 32'(key_press), 32'h0);
    step(1);
    check("t033_release_gone", 32'(key_release), 32'h0);
    step(2);
    check("t033_no_evt", 32'({evt_if.evt_valid, overflow}), 32'h0);
    key = 4'hF;
    step(8);
    check("t033_idle_level", 32'(key_level), 32'h0);
    evt_if.evt_ready = 1'b0;

    // Overflow: KEY[2] pressed three times with the output stage stalled
    key = 4'b1011;
    step(6);
    check("t031_press1", 32'(key_press), 32'h4);
    step(2);
    check("t031_evt1", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h6);
    key = 4'hF;
    step(6);
    check("t031_release1", 32'(key_release), 32'h4);
    key = 4'b1011;
    step(6);
    check("t031_press2", 32'(key_press), 32'h4);
    step(1);
    check("t031_no_ovf", 32'(overflow), 32'h0);
    check("t031_held", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h6);
    key = 4'hF;
    step(6);
    key = 4'b1011;
    step(6);
    check("t031_press3", 32'(key_press), 32'h4);
    check("t031_ovf_early", 32'(overflow), 32'h0);
    step(1);
    check("t031_ovf", 32'(overflow), 32'h1);
    check("t031_held2", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h6);
    step(2);
    check("t031_ovf_sticky", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    step(1);
    overflow_clr = 1'b0;
    check("t031_ovf_clr", 32'(overflow), 32'h0);
    evt_if.evt_ready = 1'b1;
    step(1);
    check("t031_evt2", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h6);
    step(1);
    check("t031_drained", 32'(evt_if.evt_valid), 32'h0);
    evt_if.evt_ready = 1'b0;
    key = 4'hF;
    step(8);
    check("t031_ovf_stays", 32'(overflow), 32'h0);

    // Reset mid-debounce with KEY[0] held
    key = 4'b1110;
    step(3);
    rst_n = 1'b0;
    #1;
    check("t032_rst_async", 32'({key_level, key_press, key_release, evt_if.evt_valid, overflow}), 32'h0);
    step(2);
    check("t032_rst_hold", 32'({key_level, key_press, evt_if.evt_valid}), 32'h0);
    rst_n = 1'b1;
    step(5);
    check("t032_level_early", 32'(key_level), 32'h0);
    step(1);
    check("t032_level", 32'(key_level), 32'h1);
    check("t032_press", 32'(key_press), 32'h1);
    step(2);
    check("t032_evt", 32'({evt_if.evt_valid, evt_if.evt_key}), 32'h4);

    // Reset with an event presented discards it
    key = 4'hF;
    step(1);
    rst_n = 1'b0;
    #1;
    check("t027_rst_evt", 32'({evt_if.evt_valid, key_level}), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check("t027_after", 32'({key_level, key_press, key_release, evt_if.evt_valid}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
